// File: rtl/lap_timer_pkg.sv
// -----------------------------------------------------------------------------
// lap_timer_pkg
// Shared types and helpers for the bcd_lap_timer stopwatch core.
//   state_t   : controller states (IDLE, RUN, PAUSE, LAP)
//   BCD_MAX   : highest value of one decade digit
//   digits_t  : four packed BCD digits, index 3 = tens of seconds,
//               index 0 = hundredths
//   calc_div  : prescaler divide ratio, clock cycles per count tick
// -----------------------------------------------------------------------------
package lap_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0][3:0] digits_t;

    // TICK_HZ must divide CLK_HZ exactly and the ratio must be at least 2.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One decade (0..9) of the stopwatch count. Counters are chained by feeding
// each carry into the next digit's inc, so a tick ripples through all four
// digits in the cycle it occurs.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear, wins over inc
//   inc      in   advance by one this cycle
//   q        out  registered digit value, BCD
//   carry    out  inc while q is 9 (digit wraps to 0)
// -----------------------------------------------------------------------------
module bcd_digit_counter
    import lap_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = inc && (q == BCD_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_lap_timer.sv
// -----------------------------------------------------------------------------
// bcd_lap_timer
// Four-digit BCD stopwatch (SS.hh) with start/stop, lap freeze and clear.
// Digits d3..d0 feed seven_seg_mux hex3..hex0.
//
// Parameters:
//   CLK_HZ   input clock frequency
//   TICK_HZ  count rate; DIV = CLK_HZ / TICK_HZ clock cycles per hundredth,
//            DIV must be >= 2
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   start_stop  in   one-cycle pulse, toggles run/pause
//   lap         in   one-cycle pulse, lap freeze/release; clears when paused
//   clr         in   synchronous clear, highest priority
//   d3..d0      out  displayed digits (lap latch in LAP, live count otherwise)
//   running     out  high in RUN or LAP
//   lap_active  out  high in LAP
//   ovf         out  sticky wrap/saturation flag
//
// Build option: define BCD_LAP_TIMER_SAT_EN to saturate at 99.99 (hold the
// count, set ovf, force PAUSE, block start_stop until cleared) instead of
// wrapping to 00.00.
// -----------------------------------------------------------------------------
module bcd_lap_timer
    import lap_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clr,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       running,
    output logic       lap_active,
    output logic       ovf
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    digits_t       live;
    digits_t       latch_q;
    logic [3:0]    carry;
    logic [3:0]    inc;
    logic          counting;
    logic          tick;
    logic          wrap;
    logic          sat_hold;
    logic          ss_eff;
    logic          clear_cnt;
    logic          capture;
    logic          count_inc;

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PRESC_MAX);

`ifdef BCD_LAP_TIMER_SAT_EN
    // A tick at 99.99 is swallowed; carry[3] cannot fire while saturating.
    assign sat_hold = tick && (live == {BCD_MAX, BCD_MAX, BCD_MAX, BCD_MAX});
    assign wrap     = sat_hold || carry[3];
    // After saturation the only ways out of PAUSE are clr, reset or lap.
    assign ss_eff   = start_stop && !((state == PAUSE) && ovf);
`else
    assign sat_hold = 1'b0;
    assign wrap     = carry[3];
    assign ss_eff   = start_stop;
`endif

    assign count_inc = tick && !sat_hold;

    // Decade chain: hundredths (0) -> tenths -> seconds -> tens of seconds (3).
    assign inc[0] = count_inc;
    assign inc[1] = carry[0];
    assign inc[2] = carry[1];
    assign inc[3] = carry[2];

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clear_cnt),
            .inc     (inc[i]),
            .q       (live[i]),
            .carry   (carry[i])
        );
    end

    // Next-state decode; priority clr > start_stop > lap.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        clear_cnt  = clr;
        capture    = 1'b0;
        if (clr) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ss_eff) state_next = RUN;
                end
                RUN: begin
                    if (ss_eff) begin
                        state_next = PAUSE;
                    end else if (lap) begin
                        state_next = LAP;
                        capture    = 1'b1;
                    end
                end
                LAP: begin
                    if (ss_eff)   state_next = PAUSE;
                    else if (lap) state_next = RUN;
                end
                PAUSE: begin
                    if (ss_eff) begin
                        state_next = RUN;
                    end else if (lap) begin
                        state_next = IDLE;
                        clear_cnt  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
            // Saturation overrides any other transition in that cycle.
            if (sat_hold) state_next = PAUSE;
        end
    end

    // Controller state with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
            latch_q    <= '0;
        end else begin
            state      <= state_next;
            running    <= (state_next == RUN) || (state_next == LAP);
            lap_active <= (state_next == LAP);
            if (clear_cnt)  ovf <= 1'b0;
            else if (wrap)  ovf <= 1'b1;
            // Latch takes the pre-increment count when a tick coincides.
            if (clear_cnt)    latch_q <= '0;
            else if (capture) latch_q <= live;
        end
    end

    // Prescaler holds in PAUSE so a resumed run keeps its partial hundredth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (clear_cnt) begin
            presc <= '0;
        end else if (counting) begin
            presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
        end
    end

    // Mux of registered values only; lap_active mirrors state == LAP.
    assign {d3, d2, d1, d0} = lap_active ? latch_q : live;

endmodule

// File: doc/bcd_lap_timer.md
Name: bcd_lap_timer

Overview:
Four-digit BCD stopwatch core with start/stop, lap-freeze and clear control, timing SS.hh (tens of seconds, seconds, tenths, hundredths).
Sits directly upstream of seven_seg_mux: d3..d0 drive hex3..hex0.
Control pulses come from the board's debounced button/switch edge logic.
Replaces the simple go/clr counter in timing-display designs that need lap capture.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz
TICK_HZ, 100, count rate in Hz; must divide CLK_HZ; DIV = CLK_HZ/TICK_HZ
(DIV must be >= 2)

Ports:
clk  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
start_stop  input  1  single-cycle synchronous pulse: toggle run/pause
lap  input  1  single-cycle synchronous pulse: lap freeze/release; clears when paused
clr  input  1  synchronous clear, level or pulse, highest priority
d3  output  4  displayed tens of seconds, BCD
d2  output  4  displayed seconds, BCD
d1  output  4  displayed tenths, BCD
d0  output  4  displayed hundredths, BCD
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP (display frozen)
ovf  output  1  sticky; set on 99.99 -> 00.00 wrap

Behaviour:
- Reset (reset_n=0, async): state IDLE; prescaler, live count and lap latch all zero; d3..d0=0; running=0; lap_active=0; ovf=0.
- Prescaler 0..DIV-1:
  - advances only in RUN/LAP; tick when prescaler==DIV-1, then wraps to 0.
  - holds its value in PAUSE (no lost fraction); zeroed in IDLE and on clr.
- Live count: four cascaded decade counters, each 0..9.
  - Tick increments d0; carry ripples combinationally in the same cycle.
  - Counter outputs are registered; new value is visible the cycle after the tick.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: start_stop -> RUN; lap ignored.
  - RUN: start_stop -> PAUSE; lap -> LAP, latching the live count present in that cycle (pre-increment if a tick coincides).
  - LAP: count keeps running, outputs show the latch; lap -> RUN (outputs live next cycle); start_stop -> PAUSE (outputs revert to live).
  - PAUSE: start_stop -> RUN; lap -> IDLE with count, prescaler and ovf zeroed.
- Priority within one cycle: clr > start_stop > lap.
- clr in any state -> IDLE, everything zeroed as at reset, next cycle.
- Outputs: d3..d0 = lap latch in LAP, live count otherwise; registered path, no combinational path from inputs.
- Wrap: a tick at 99.99 -> 00.00 and sets ovf; ovf stays set until clr, reset, or the PAUSE+lap clear.
- reset_n asserted mid-count: immediate async return to reset values; first tick after release occurs DIV cycles after the start_stop pulse.

Optional Feature:
BCD_LAP_TIMER_SAT_EN
- Defined: a tick at 99.99 holds 99.99, sets ovf and forces state PAUSE; a LAP latch is discarded and outputs show 99.99. start_stop in PAUSE while ovf=1 is ignored; only clr, reset, or lap (PAUSE -> IDLE) leave it.
- Undefined: wrap behaviour as above.

Decomposition:
- Package lap_timer_pkg:
  - state enum (IDLE, RUN, PAUSE, LAP)
  - BCD_MAX = 4'd9
  - 4x4-bit digit bundle typedef
  - function computing DIV from CLK_HZ/TICK_HZ
- Sub-module bcd_digit_counter: one decade; inputs clk, reset_n, clr, inc; outputs q[3:0], carry (inc && q==9). Instantiated four times, chained via carry.

Test Plan:
(CLK_HZ=1000, TICK_HZ=100, DIV=10 unless noted.)
1. Reset release; start_stop at cycle 0; wait 250 cycles -> d=0,0,2,5; running=1; ovf=0.
2. Run 123 ticks, start_stop, wait 500 cycles -> d holds 0,1,2,3. start_stop again -> first new tick exactly 10 - (held prescaler) cycles later.
3. Run to 0,0,5,0, lap -> outputs frozen at 0050, lap_active=1 while the live count advances; after 300 cycles lap -> outputs show 0,0,8,0 next cycle.
4. Run to 99.99, one more tick -> 00.00, ovf=1. With BCD_LAP_TIMER_SAT_EN: 99.99 held, state PAUSE, start_stop ignored.
5. clr and start_stop in the same cycle during RUN -> IDLE, all outputs 0. PAUSE + lap -> IDLE with ovf cleared.
6. reset_n low for 1 ns between clock edges mid-run -> outputs zero immediately (asynchronously); FSM in IDLE after release.
